// File: rtl/q_result_checker.sv
// Run-and-check engine: launches one DUT run, times it under a watchdog,
// then compares the output SRAM against a golden SRAM within a ULP tolerance.
module q_result_checker #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128,
  parameter int TOL_ULP    = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [CNT_WIDTH-1:0]  timeout,
  output logic                  dut_valid,
  input  logic                  dut_ready,
  output logic [ADDR_WIDTH-1:0] out_sram_read_address,
  input  logic [DATA_WIDTH-1:0] out_sram_read_data,
  output logic [ADDR_WIDTH-1:0] gold_sram_read_address,
  input  logic [DATA_WIDTH-1:0] gold_sram_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic [ADDR_WIDTH:0]   pass_count,
  output logic [ADDR_WIDTH:0]   fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_DONE, COMPARE, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   W_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [CNT_WIDTH:0]    C_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH:0]   num_q;
  logic [CNT_WIDTH-1:0]  timeout_q;
  logic                  cmp_valid;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  logic [ADDR_WIDTH:0]   last_idx;
  logic                  last_addr;
  logic [CNT_WIDTH:0]    cnt_inc;
  logic                  wd_hit;
  logic                  word_ok;
  logic                  unused_signs;

  function automatic logic field_ok(input logic [62:0] a,
                                    input logic [62:0] b);
    logic [63:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b})
                 : ({1'b0, b} - {1'b0, a});
    return d <= 64'(TOL_ULP);
  endfunction

  assign last_idx  = num_q - W_ONE;
  assign last_addr = ({1'b0, out_sram_read_address} == last_idx);
  assign cnt_inc   = {1'b0, cycle_count} + C_ONE;
  assign wd_hit    = (timeout_q != '0) &&
                     (cnt_inc >= {1'b0, timeout_q});

  // Sign bits are deliberately excluded from the tolerance check
  assign word_ok =
    field_ok(out_sram_read_data[126:64], gold_sram_read_data[126:64]) &&
    field_ok(out_sram_read_data[62:0],   gold_sram_read_data[62:0]);

  assign unused_signs = ^{out_sram_read_data[127], out_sram_read_data[63],
                          gold_sram_read_data[127], gold_sram_read_data[63]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      num_q                  <= '0;
      timeout_q              <= '0;
      cmp_valid              <= 1'b0;
      cmp_addr               <= '0;
      dut_valid              <= 1'b0;
      out_sram_read_address  <= '0;
      gold_sram_read_address <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      timed_out              <= 1'b0;
      pass_count             <= '0;
      fail_count             <= '0;
      first_fail_addr        <= '0;
      cycle_count            <= '0;
    end else begin
      done      <= 1'b0;
      cmp_valid <= (state == COMPARE);
      cmp_addr  <= out_sram_read_address;

      // Word k is judged one cycle after its address was issued
      if (cmp_valid) begin
        if (word_ok) begin
          pass_count <= pass_count + W_ONE;
        end else begin
          if (fail_count == '0) first_fail_addr <= cmp_addr;
          fail_count <= fail_count + W_ONE;
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            num_q           <= num_words;
            timeout_q       <= timeout;
            pass_count      <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            cycle_count     <= '0;
            timed_out       <= 1'b0;
            dut_valid       <= 1'b1;
            busy            <= 1'b1;
            state           <= LAUNCH;
          end
        end
        LAUNCH: begin
          cycle_count <= cnt_inc[CNT_WIDTH-1:0];
          if (wd_hit) begin
            timed_out <= 1'b1;
            dut_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (!dut_ready) begin
            dut_valid <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cycle_count <= cnt_inc[CNT_WIDTH-1:0];
          if (dut_ready) begin
            if (num_q == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= COMPARE;
            end
          end else if (wd_hit) begin
            timed_out <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        COMPARE: begin
          if (last_addr) begin
            out_sram_read_address  <= '0;
            gold_sram_read_address <= '0;
            state                  <= DRAIN;
          end else begin
            out_sram_read_address  <= out_sram_read_address + A_ONE;
            gold_sram_read_address <= gold_sram_read_address + A_ONE;
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_result_checker.sv
// Scoreboard bench for q_result_checker: randomized runs against a
// behavioural model of the DUT handshake and the word-tolerance rule.
module tb_q_result_checker;

  localparam int AW  = 12;
  localparam int DW  = 128;
  localparam int TOL = 1;
  localparam int CW  = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [CW-1:0] timeout = '0;
  logic          dut_valid;
  logic          dut_ready = 1'b1;
  logic [AW-1:0] out_addr, gold_addr;
  logic [DW-1:0] out_rdata = '0, gold_rdata = '0;
  logic          busy, done, timed_out;
  logic [AW:0]   pass_count, fail_count;
  logic [AW-1:0] first_fail_addr;
  logic [CW-1:0] cycle_count;

  q_result_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TOL_ULP(TOL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_words(num_words), .timeout(timeout),
    .dut_valid(dut_valid), .dut_ready(dut_ready),
    .out_sram_read_address(out_addr), .out_sram_read_data(out_rdata),
    .gold_sram_read_address(gold_addr), .gold_sram_read_data(gold_rdata),
    .busy(busy), .done(done), .timed_out(timed_out),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_addr(first_fail_addr), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] out_mem  [DEPTH];
  logic [DW-1:0] gold_mem [DEPTH];

  always @(posedge clk) begin
    out_rdata  <= out_mem[out_addr];
    gold_rdata <= gold_mem[gold_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // DUT behaviour: ready drops drop_d cycles after valid rises, stays
  // low busy_l cycles (forever if negative), then returns high.
  int drop_d = 0;
  int busy_l = 1;
  int k = 0;
  always @(negedge clk) begin
    if (reset || !busy) begin
      k = 0;
      dut_ready = 1'b1;
    end else begin
      if (k > 0 || dut_valid) k = k + 1;
      if (k > 0)
        dut_ready = !(k >= drop_d + 1 && (busy_l < 0 || k <= drop_d + busy_l));
    end
  end

  typedef struct {
    int pass_c;
    int fail_c;
    int ffa;
    int tmo;
    int cyc;
    int vcyc;
    int max_addr;
  } exp_t;

  exp_t sb[$];

  function automatic bit word_pass(input logic [127:0] o,
                                   input logic [127:0] g);
    longint unsigned orl, grl, oim, gim, dr, di;
    orl = longint'(o[126:64]);
    grl = longint'(g[126:64]);
    oim = longint'(o[62:0]);
    gim = longint'(g[62:0]);
    dr = (orl > grl) ? orl - grl : grl - orl;
    di = (oim > gim) ? oim - gim : gim - oim;
    return (dr <= TOL) && (di <= TOL);
  endfunction

  function automatic exp_t model(input int n, input int d, input int l,
                                 input int tmo);
    exp_t e;
    int cyc;
    bit completed;
    cyc = (l < 0) ? -1 : d + l + 1;
    completed = (l >= 0) && (tmo == 0 || cyc <= tmo);
    e.pass_c = 0;
    e.fail_c = 0;
    e.ffa = 0;
    e.tmo = completed ? 0 : 1;
    e.cyc = completed ? cyc : -1;
    e.vcyc = (tmo == 0 || d + 1 < tmo) ? d + 1 : tmo;
    e.max_addr = (completed && n > 0) ? n - 1 : 0;
    if (completed) begin
      for (int i = 0; i < n; i++) begin
        if (word_pass(out_mem[i], gold_mem[i])) e.pass_c++;
        else begin
          if (e.fail_c == 0) e.ffa = i;
          e.fail_c++;
        end
      end
    end
    return e;
  endfunction

  // Monitor: accumulates per-run observations, checks at each done pulse
  int vcnt = 0;
  int amax = 0;
  bit amis = 0;
  bit chk_next = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        check("done_single", done, 0);
        check("busy_after_done", busy, 0);
        chk_next = 0;
      end
      if (reset) begin
        vcnt = 0; amax = 0; amis = 0;
      end else begin
        if (dut_valid) vcnt++;
        if (int'(out_addr) > amax) amax = int'(out_addr);
        if (out_addr != gold_addr) amis = 1;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("pass_count", pass_count, e.pass_c);
            check("fail_count", fail_count, e.fail_c);
            check("first_fail_addr", first_fail_addr, e.ffa);
            check("timed_out", timed_out, e.tmo);
            if (e.cyc >= 0) check("cycle_count", cycle_count, e.cyc);
            check("valid_cycles", vcnt, e.vcyc);
            check("max_addr", amax, e.max_addr);
            check("addr_match", amis, 0);
            check("busy_at_done", busy, 1);
          end
          chk_next = 1;
          vcnt = 0; amax = 0; amis = 0;
        end
      end
    end
  end

  task automatic kick(input int n, input int d, input int l, input int tmo);
    @(negedge clk);
    num_words = (AW+1)'(n);
    timeout = CW'(tmo);
    drop_d = d;
    busy_l = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("done_seen", got, 1);
  endtask

  task automatic run(input int n, input int d, input int l, input int tmo,
                     input bit extra_start);
    sb.push_back(model(n, d, l, tmo));
    kick(n, d, l, tmo);
    if (extra_start) begin
      repeat (3) @(negedge clk);
      num_words = 7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill(input int n, input bit perturb);
    logic [62:0] f;
    int r;
    for (int i = 0; i < n; i++) begin
      out_mem[i] = rand_word();
      gold_mem[i] = out_mem[i];
      if (perturb) begin
        r = $urandom_range(0, 5);
        case (r)
          1: gold_mem[i] = out_mem[i] ^ {1'b1, 63'd0, 1'b1, 63'd0};
          2: begin
            f = out_mem[i][126:64] + 63'd1;
            gold_mem[i][126:64] = f;
          end
          3: begin
            f = out_mem[i][62:0] - 63'd1;
            gold_mem[i][62:0] = f;
          end
          4: begin
            f = out_mem[i][62:0] + 63'd2;
            gold_mem[i][62:0] = f;
          end
          5: gold_mem[i] = rand_word();
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    logic [62:0] f;
    bit hit;
    int n, d, l, tmo, cyc;

    for (int i = 0; i < DEPTH; i++) begin
      out_mem[i] = '0;
      gold_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_valid", dut_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_count, 0);
    check("rst_cycles", cycle_count, 0);
    reset = 1'b0;

    // Nominal run
    fill(72, 0);
    run(72, 2, 50, 0, 0);

    // Tolerance boundary: sign-only, +1 real, +2 imag
    fill(16, 0);
    for (int i = 0; i < 16; i++) begin
      out_mem[i][126] = 1'b0;
      out_mem[i][62] = 1'b0;
      gold_mem[i] = out_mem[i];
    end
    gold_mem[3] = out_mem[3] ^ {1'b1, 63'd0, 1'b1, 63'd0};
    f = out_mem[5][126:64] + 63'd1;
    gold_mem[5][126:64] = f;
    f = out_mem[9][62:0] + 63'd2;
    gold_mem[9][62:0] = f;
    run(16, 0, 10, 100, 0);
    check("tol_fail_count", fail_count, 1);
    check("tol_first_fail", first_fail_addr, 9);

    // Watchdog: ready never returns
    run(10, 3, -1, 20, 0);

    // Zero length
    run(0, 1, 5, 0, 0);

    // Full depth, every word mismatched
    for (int i = 0; i < DEPTH; i++) begin
      out_mem[i] = rand_word();
      gold_mem[i] = out_mem[i] ^ (128'd1 << 100) ^ (128'd1 << 5);
    end
    run(DEPTH, 1, 3, 0, 0);
    check("full_fail_count", fail_count, DEPTH);

    // Reset mid-compare at word 30
    fill(72, 1);
    kick(72, 1, 4, 0);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (out_addr == 30) hit = 1;
    end
    check("reached_word30", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", dut_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_timed_out", timed_out, 0);
    check("mid_rst_pass", pass_count, 0);
    check("mid_rst_fail", fail_count, 0);
    check("mid_rst_ffa", first_fail_addr, 0);
    check("mid_rst_cycles", cycle_count, 0);
    check("mid_rst_out_addr", out_addr, 0);
    check("mid_rst_gold_addr", gold_addr, 0);
    reset = 1'b0;
    run(72, 1, 4, 0, 0);

    // Back-to-back with an ignored start while busy
    fill(40, 1);
    run(40, 2, 8, 0, 1);
    fill(25, 1);
    run(25, 0, 3, 0, 0);

    // Randomized runs
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 200);
      d = $urandom_range(0, 4);
      l = $urandom_range(1, 30);
      cyc = d + l + 1;
      case ($urandom_range(0, 4))
        0: tmo = 0;
        1: tmo = $urandom_range(2, cyc - 1);
        default: tmo = cyc + $urandom_range(1, 20);
      endcase
      fill(n, 1);
      run(n, d, l, tmo, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_result_checker.md
# q_result_checker

Synthesizable, parametrised run-and-check engine for the quantum-state emulator. It launches one `MyDesign` computation over the `dut_valid`/`dut_ready` handshake and measures its latency with a timeout watchdog. It then streams the q_state_output SRAM against a golden SRAM and reports pass/fail counts with a ULP tolerance. It sits beside the DUT and the SRAM models, so regressions and FPGA bring-up run without a simulator-side checker.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: SRAM address width, for both the output and golden SRAMs.
- `DATA_WIDTH`, 128: SRAM word width. Must be 128: {sign, 63-bit real magnitude, sign, 63-bit imag magnitude}.
- `TOL_ULP`, 1: maximum allowed unsigned difference per 63-bit field.
- `CNT_WIDTH`, 32: width of the cycle counter and the timeout input.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — request one run; sampled only in IDLE.
- `num_words`  in  ADDR_WIDTH+1  — words to compare, 0..2^ADDR_WIDTH; latched on start.
- `timeout`  in  CNT_WIDTH  — watchdog limit in cycles; latched on start.
- `dut_valid`  out  1  — handshake request to the DUT.
- `dut_ready`  in  1  — DUT ready/done.
- `out_sram_read_address`  out  ADDR_WIDTH  — read address to the q_state_output SRAM.
- `out_sram_read_data`  in  DATA_WIDTH  — read data; valid one cycle after the address.
- `gold_sram_read_address`  out  ADDR_WIDTH  — read address to the golden SRAM.
- `gold_sram_read_data`  in  DATA_WIDTH  — read data; valid one cycle after the address.
- `busy`  out  1  — high from the cycle after start until the cycle done pulses.
- `done`  out  1  — single-cycle completion pulse.
- `timed_out`  out  1  — the run ended by watchdog.
- `pass_count`  out  ADDR_WIDTH+1  — words within tolerance.
- `fail_count`  out  ADDR_WIDTH+1  — words outside tolerance.
- `first_fail_addr`  out  ADDR_WIDTH  — address of the first failing word; 0 if none.
- `cycle_count`  out  CNT_WIDTH  — DUT latency in cycles.

## Operation
States: IDLE, LAUNCH, WAIT_DONE, COMPARE, DRAIN, DONE.
- **IDLE**
  - On `start`: latch `num_words` and `timeout`; clear the counters, `first_fail_addr` and `timed_out`; go to LAUNCH.
  - `start` in any other state is ignored.
- **LAUNCH**
  - `dut_valid`=1 and `cycle_count` increments every cycle.
  - When `dut_ready`==0 is sampled, deassert `dut_valid` and go to WAIT_DONE.
- **WAIT_DONE**
  - `cycle_count` increments.
  - When `dut_ready`==1 is sampled, go to COMPARE, or to DONE if `num_words`==0.
- **Watchdog**
  - Active in LAUNCH and WAIT_DONE.
  - When `cycle_count` reaches `timeout`: set `timed_out`=1, drop `dut_valid`, go to DONE and skip the compare.
  - `timeout`=0 disables the watchdog.
- **COMPARE**
  - Issue addresses 0..`num_words`-1 to both SRAMs, one per cycle, identical on both.
  - Go to DRAIN after the last address is issued.
- **DRAIN**
  - One cycle to compare the last word, then go to DONE.
- **Compare rule** (one-stage pipeline; word k is evaluated on the cycle after address k):
  - Sign bits 127 and 63 are ignored.
  - Real field [126:64] and imag field [62:0] are treated as unsigned.
  - The word passes iff |out−gold| ≤ `TOL_ULP` for both fields.
  - The difference uses 64-bit unsigned arithmetic; no saturation is needed.
  - A pass increments `pass_count`.
  - A fail increments `fail_count`. If it is the first fail, its address (delayed by one cycle to match the data) is captured in `first_fail_addr`.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - Results hold until the next accepted `start`.

## Timing
- Reset values: `dut_valid`=0, `busy`=0, `done`=0, `timed_out`=0, all counts 0, both read addresses 0, state IDLE.
- `reset` mid-run aborts immediately. All outputs take their reset values at the next edge, including `dut_valid`=0.
- `start` is sampled at edge t, so `dut_valid`=1 and `busy`=1 from t+1.
- `cycle_count` equals the number of cycles from `dut_valid` rising to `dut_ready` being sampled high, inclusive of both.
- Compare phase: `num_words` address cycles + 1 drain cycle. `done` follows the drain cycle by one cycle.
- If `dut_ready` is already low in the first LAUNCH cycle, `dut_valid` lasts exactly 1 cycle.
- Read addresses are 0 outside COMPARE.

## Test plan
- **Nominal run.** Reset; DUT model drops `dut_ready` 2 cycles after valid and raises it 50 cycles later. Golden equals output, `num_words`=72. Expect `dut_valid` high for 3 cycles, `pass_count`=72, `fail_count`=0, `timed_out`=0, one `done` pulse.
- **Tolerance boundary.** Word 5 real field differs by exactly `TOL_ULP`=1 → passes. Word 9 imag field differs by 2 → `fail_count`=1, `first_fail_addr`=9. Sign-bit-only difference on word 3 → passes.
- **Watchdog.** `timeout`=20 and `dut_ready` never returns high. Expect `timed_out`=1, `done` pulse, zero counts, read addresses stay 0.
- **Zero length and full depth.** `num_words`=0 → `done` with zero counts and no address activity. `num_words`=4096 with all words mismatched → `fail_count`=4096, `first_fail_addr`=0.
- **Reset mid-COMPARE.** Assert `reset` at word 30. Expect all outputs at reset values the next cycle; a subsequent run completes normally.
- **Back-to-back runs.** Pulse `start` while busy → ignored. A second run immediately after `done` clears the previous counts and reports fresh results.
